// File: rtl/enc4x2_reg.sv
// Registered 4-to-2 priority encoder with input sync,
// debounce and a valid/ack report handshake.
module enc4x2_reg #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       SYSCLK,
    input  logic       SYSRESET,
    input  logic       en,
    input  logic [3:0] d,
    input  logic       ack,
    output logic [1:0] y,
    output logic       multi,
    output logic       valid
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    last_q, stable_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    y_q;
    logic          multi_q;
    logic          valid_q, valid_d;
    logic          cap;
    logic [1:0]    enc_y;
    logic          enc_multi;

    // Two-flop synchroniser, then hold-time qualification into stable_q
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            s1_q     <= '0;
            s2_q     <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            if (s2_q != last_q) begin
                last_q <= s2_q;
                cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                stable_q <= last_q;
            end
        end
    end

    // Priority encode of the debounced lines; multi = more than one bit set
    always_comb begin
        enc_y = 2'd0;
        if (stable_q[3])      enc_y = 2'd3;
        else if (stable_q[2]) enc_y = 2'd2;
        else if (stable_q[1]) enc_y = 2'd1;
        else                  enc_y = 2'd0;
        enc_multi = (stable_q & (stable_q - 4'd1)) != 4'd0;
    end

    // Report FSM next state: one report per press, re-arm on all-zero
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && (stable_q != 4'd0)) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    cap     = 1'b1;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (ack) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                end
            end
            RELEASE: begin
                if (stable_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, valid flag and captured index; y/multi change only on capture
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            y_q     <= 2'd0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (cap) begin
                y_q     <= enc_y;
                multi_q <= enc_multi;
            end
        end
    end

    assign y     = y_q;
    assign multi = multi_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_enc4x2_reg.sv
// Randomised and directed bench for enc4x2_reg against
// a sample-window debounce model and a report-level handshake model.
module tb_enc4x2_reg;

    localparam int DB = 4;

    logic       SYSCLK;
    logic       SYSRESET;
    logic       en;
    logic [3:0] d;
    logic       ack;
    logic [1:0] y;
    logic       multi;
    logic       valid;

    int n_vec;
    int n_err;

    // model state
    logic [3:0] hist [0:DB+2];
    logic [3:0] m_stable;
    logic       m_valid;
    logic       m_wait0;
    logic [1:0] m_y;
    logic       m_multi;

    enc4x2_reg #(.DEBOUNCE_CYCLES(DB)) dut (
        .SYSCLK   (SYSCLK),
        .SYSRESET (SYSRESET),
        .en       (en),
        .d        (d),
        .ack      (ack),
        .y        (y),
        .multi    (multi),
        .valid    (valid)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= DB + 2; j++) hist[j] = 4'd0;
        m_stable = 4'd0;
        m_valid  = 1'b0;
        m_wait0  = 1'b0;
        m_y      = 2'd0;
        m_multi  = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    // A value is accepted once DB+1 consecutive edge samples agree
    // (two sync stages plus the DB-cycle qualification window).
    task automatic model_edge();
        logic       same;
        int         top;
        if (SYSRESET) begin
            model_reset();
            return;
        end
        if (m_valid) begin
            if (!en) begin
                m_valid = 1'b0;
            end else if (ack) begin
                m_valid = 1'b0;
                m_wait0 = 1'b1;
            end
        end else if (m_wait0) begin
            if (m_stable == 4'd0) m_wait0 = 1'b0;
        end else if (en && m_stable != 4'd0) begin
            top = 0;
            for (int i = 0; i < 4; i++) if (m_stable[i]) top = i;
            m_y     = 2'(top);
            m_multi = ($countones(m_stable) > 1);
            m_valid = 1'b1;
        end
        for (int j = DB + 2; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = d;
        same = 1'b1;
        for (int j = 3; j <= DB + 2; j++)
            if (hist[j] != hist[2]) same = 1'b0;
        if (same) m_stable = hist[2];
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        model_edge();
        #1;
        chk("out", {5'd0, valid, multi, y}, {5'd0, m_valid, m_multi, m_y});
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic release_all(input int n);
        d = 4'd0;
        repeat (n) tick();
    endtask

    logic [3:0] sweep_d [4];
    logic [1:0] sweep_y [4];
    logic       sweep_m [4];

    initial begin
        int n;
        logic seen;
        int hold;

        n_vec = 0;
        n_err = 0;
        sweep_d = '{4'b0001, 4'b0010, 4'b1000, 4'b0110};
        sweep_y = '{2'd0, 2'd1, 2'd3, 2'd2};
        sweep_m = '{1'b0, 1'b0, 1'b0, 1'b1};

        // reset with all requests active
        SYSRESET = 1'b1;
        en       = 1'b1;
        ack      = 1'b0;
        d        = 4'b1111;
        model_reset();
        #1;
        chk("rst0", {5'd0, valid, multi, y}, 8'd0);
        repeat (3) tick();
        #2 SYSRESET = 1'b0;
        wait_valid(20, n);
        chk("rst_lat", 8'(n), 8'd7);
        chk("rst_y", {6'd0, y}, 8'd3);
        chk("rst_multi", {7'd0, multi}, 8'd1);
        ack_pulse();
        release_all(12);

        // single request, held long after ack
        d = 4'b0100;
        wait_valid(20, n);
        chk("one_lat", 8'(n), 8'd7);
        chk("one_y", {6'd0, y}, 8'd2);
        chk("one_multi", {7'd0, multi}, 8'd0);
        ack_pulse();
        chk("one_ack", {7'd0, valid}, 8'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= valid;
        end
        chk("one_norep", {7'd0, seen}, 8'd0);
        release_all(12);

        // priority sweep
        for (int k = 0; k < 4; k++) begin
            d = sweep_d[k];
            wait_valid(20, n);
            chk("sw_lat", 8'(n), 8'd7);
            chk("sw_y", {6'd0, y}, {6'd0, sweep_y[k]});
            chk("sw_multi", {7'd0, multi}, {7'd0, sweep_m[k]});
            ack_pulse();
            release_all(10);
        end

        // short pulse is filtered out
        d = 4'b0010;
        seen = 1'b0;
        repeat (DB - 1) begin
            tick();
            seen |= valid;
        end
        d = 4'b0000;
        repeat (12) begin
            tick();
            seen |= valid;
        end
        chk("glitch_nv", {7'd0, seen}, 8'd0);
        chk("glitch_stb", {4'd0, dut.stable_q}, 8'd0);

        // pulse long enough to fill the qualification window
        d = 4'b0010;
        seen = 1'b0;
        repeat (DB + 1) begin
            tick();
            seen |= valid;
        end
        d = 4'b0000;
        repeat (6) begin
            tick();
            seen |= valid;
        end
        chk("pulse_v", {7'd0, seen}, 8'd1);
        chk("pulse_y", {6'd0, y}, 8'd1);
        ack_pulse();
        release_all(12);

        // enable abort, en low beats ack
        d = 4'b1000;
        wait_valid(20, n);
        chk("ab_y0", {6'd0, y}, 8'd3);
        en  = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ab_v", {7'd0, valid}, 8'd0);
        chk("ab_y", {6'd0, y}, 8'd3);
        release_all(12);
        d = 4'b1000;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= valid;
        end
        chk("ab_blk", {7'd0, seen}, 8'd0);
        en = 1'b1;
        wait_valid(3, n);
        chk("ab_recap", 8'(n), 8'd0);
        chk("ab_ry", {6'd0, y}, 8'd3);
        ack_pulse();
        release_all(12);

        // asynchronous reset in the middle of a report
        d = 4'b0100;
        wait_valid(20, n);
        chk("ar_pre", {7'd0, valid}, 8'd1);
        #2 SYSRESET = 1'b1;
        model_reset();
        #1;
        chk("ar_async", {5'd0, valid, multi, y}, 8'd0);
        repeat (2) tick();
        #2 SYSRESET = 1'b0;
        wait_valid(20, n);
        chk("ar_lat", 8'(n), 8'd7);
        chk("ar_y", {6'd0, y}, 8'd2);
        ack_pulse();
        release_all(12);

        // randomised traffic against the model
        hold = 0;
        for (int t = 0; t < 2000; t++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) d = 4'd0;
                else d = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 9);
            end
            hold--;
            en  = ($urandom_range(0, 15) != 0);
            ack = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
